// File: rtl/al_seq_reader.sv
// Read-out engine for the aligned-sequence RAMs: walks addresses 0..len-1, decodes the
// 3-bit symbol pair at each address to ASCII and offers it on a valid/ready stream.
module al_seq_reader #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BitAddr:0] len,
  output logic [BitAddr:0] rd_addr,
  input  logic [2:0]       data_a,
  input  logic [2:0]       data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       char_a,
  output logic [7:0]       char_b,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, FIN} state_t;

  localparam logic [BitAddr:0] LenMax = (BitAddr + 1)'(N);
  localparam logic [BitAddr:0] One    = (BitAddr + 1)'(1);

  state_t           state_reg, state_next;
  logic [BitAddr:0] idx_reg, idx_next;
  logic [BitAddr:0] len_reg, len_next;
  logic [BitAddr:0] addr_reg, addr_next;
  logic             valid_reg, valid_next;
  logic [7:0]       char_a_reg, char_a_next;
  logic [7:0]       char_b_reg, char_b_next;

  function automatic logic [7:0] decode(input logic [2:0] code);
    case (code)
      3'b000:  decode = 8'h41;
      3'b001:  decode = 8'h43;
      3'b010:  decode = 8'h47;
      3'b011:  decode = 8'h54;
      3'b100:  decode = 8'h2D;
      default: decode = 8'h3F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      len_reg    <= '0;
      addr_reg   <= '0;
      valid_reg  <= 1'b0;
      char_a_reg <= 8'h00;
      char_b_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      len_reg    <= len_next;
      addr_reg   <= addr_next;
      valid_reg  <= valid_next;
      char_a_reg <= char_a_next;
      char_b_reg <= char_b_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    len_next    = len_reg;
    addr_next   = addr_reg;
    valid_next  = valid_reg;
    char_a_next = char_a_reg;
    char_b_next = char_b_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            // Lengths beyond the RAM depth are clamped so the walk never leaves the RAM.
            len_next   = (len > LenMax) ? LenMax : len;
            idx_next   = '0;
            addr_next  = '0;
            state_next = ISSUE;
          end else begin
            state_next = FIN;
          end
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        char_a_next = decode(data_a);
        char_b_next = decode(data_b);
        valid_next  = 1'b1;
        state_next  = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_next = 1'b0;
          if (idx_reg < len_reg - One) begin
            idx_next   = idx_reg + One;
            addr_next  = idx_reg + One;
            state_next = ISSUE;
          end else begin
            state_next = FIN;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rd_addr   = addr_reg;
  assign out_valid = valid_reg;
  assign char_a    = char_a_reg;
  assign char_b    = char_b_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FIN);

endmodule

// File: tb/tb_al_seq_reader.sv
// Directed bench for al_seq_reader: a synchronous-read RAM model feeds the DUT and each
// scenario task checks pairs, addresses, timing and control outputs against fixed values.
module tb_al_seq_reader;
  localparam int N  = 128;
  localparam int BA = $clog2(N);
  localparam int AW = BA + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] len = '0;
  logic [AW-1:0] rd_addr;
  logic [2:0]    data_a, data_b;
  logic          out_valid, busy, done;
  logic [7:0]    char_a, char_b;

  logic [2:0] ram_a [N];
  logic [2:0] ram_b [N];

  int vectors = 0;
  int miscompares = 0;

  // Results captured by run()
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  int         q_addr [$];
  logic [7:0] st_a [$];
  logic [7:0] st_b [$];
  int         st_addr [$];
  int first_valid, done_cnt, done_cyc, busy_after, busy_first, timed_out;

  logic [7:0] exp_a [4] = '{8'h41, 8'h43, 8'h47, 8'h54};
  logic [7:0] exp_b [4] = '{8'h41, 8'h2D, 8'h47, 8'h54};

  al_seq_reader #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .rd_addr(rd_addr),
    .data_a(data_a), .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
    .char_a(char_a), .char_b(char_b), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    data_a <= ram_a[rd_addr[BA-1:0]];
    data_b <= ram_b[rd_addr[BA-1:0]];
  end

  function automatic logic [7:0] ref_char(input logic [2:0] c);
    case (c)
      3'd0: return 8'h41;
      3'd1: return 8'h43;
      3'd2: return 8'h47;
      3'd3: return 8'h54;
      3'd4: return 8'h2D;
      default: return 8'h3F;
    endcase
  endfunction

  task automatic load_basic();
    for (int i = 0; i < N; i++) begin
      ram_a[i] = 3'd0;
      ram_b[i] = 3'd0;
    end
    ram_a[0] = 3'd0; ram_a[1] = 3'd1; ram_a[2] = 3'd2; ram_a[3] = 3'd3;
    ram_b[0] = 3'd0; ram_b[1] = 3'd4; ram_b[2] = 3'd2; ram_b[3] = 3'd3;
  endtask

  // Pulses start with length ln, then consumes pairs cycle by cycle (sampled on negedge).
  // Pair stall_idx is held off for stall_n cycles; start is re-pulsed at cycle poke_cyc.
  task automatic run(input int ln, input int stall_idx, input int stall_n,
                     input int poke_cyc, input int poke_len, input int budget);
    int stalled;
    int pair;
    q_a.delete(); q_b.delete(); q_addr.delete();
    st_a.delete(); st_b.delete(); st_addr.delete();
    first_valid = -1; done_cnt = 0; done_cyc = -1;
    busy_after = -1; busy_first = -1; timed_out = 1;
    stalled = 0; pair = 0;
    @(negedge clk);
    start = 1'b1; len = AW'(ln); out_ready = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = (c == poke_cyc);
      if (c == poke_cyc) len = AW'(poke_len);
      if (c == 1) busy_first = int'(busy);
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        busy_after = int'(busy);
        timed_out = 0;
        break;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = c;
        if (pair == stall_idx && stalled < stall_n) begin
          out_ready = 1'b0;
          stalled++;
          st_a.push_back(char_a); st_b.push_back(char_b); st_addr.push_back(int'(rd_addr));
        end else begin
          out_ready = 1'b1;
          q_a.push_back(char_a); q_b.push_back(char_b); q_addr.push_back(int'(rd_addr));
          $display("pair %0d addr %0d a=%h b=%h cycle %0d", pair, rd_addr, char_a, char_b, c);
          pair++;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (rd_addr !== '0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", rd_addr); end
    vectors++; if (char_a !== 8'h00 || char_b !== 8'h00) begin
      miscompares++; $display("FAIL reset_chars got %h/%h want 00/00", char_a, char_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run(4, -1, 0, -1, 0, 100);
    vectors++; if (timed_out !== 0) begin miscompares++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
    vectors++; if (q_a.size() !== 4) begin miscompares++; $display("FAIL basic_count got %0d want 4", q_a.size()); end
    for (int i = 0; i < 4 && i < q_a.size(); i++) begin
      vectors++; if (q_a[i] !== exp_a[i] || q_b[i] !== exp_b[i] || q_addr[i] !== i) begin
        miscompares++;
        $display("FAIL basic_pair%0d got %h/%h@%0d want %h/%h@%0d", i, q_a[i], q_b[i], q_addr[i], exp_a[i], exp_b[i], i);
      end
    end
    vectors++; if (first_valid !== 3) begin miscompares++; $display("FAIL basic_latency got %0d want 3", first_valid); end
    vectors++; if (busy_first !== 1) begin miscompares++; $display("FAIL basic_busy got %0d want 1", busy_first); end
    vectors++; if (done_cnt !== 1 || done_cyc !== 13) begin
      miscompares++; $display("FAIL basic_done got %0d pulses at %0d want 1 at 13", done_cnt, done_cyc);
    end
    vectors++; if (busy_after !== 0) begin miscompares++; $display("FAIL basic_idle got %0d want 0", busy_after); end
  endtask

  task automatic test_backpressure();
    run(4, 1, 5, -1, 0, 100);
    vectors++; if (st_a.size() !== 5) begin miscompares++; $display("FAIL bp_stall_len got %0d want 5", st_a.size()); end
    for (int i = 0; i < st_a.size(); i++) begin
      vectors++; if (st_a[i] !== 8'h43 || st_b[i] !== 8'h2D || st_addr[i] !== 1) begin
        miscompares++; $display("FAIL bp_hold%0d got %h/%h@%0d want 43/2d@1", i, st_a[i], st_b[i], st_addr[i]);
      end
    end
    vectors++; if (q_a.size() !== 4) begin miscompares++; $display("FAIL bp_count got %0d want 4", q_a.size()); end
    for (int i = 0; i < 4 && i < q_a.size(); i++) begin
      vectors++; if (q_a[i] !== exp_a[i] || q_b[i] !== exp_b[i] || q_addr[i] !== i) begin
        miscompares++;
        $display("FAIL bp_pair%0d got %h/%h@%0d want %h/%h@%0d", i, q_a[i], q_b[i], q_addr[i], exp_a[i], exp_b[i], i);
      end
    end
    vectors++; if (done_cnt !== 1 || done_cyc !== 18) begin
      miscompares++; $display("FAIL bp_done got %0d pulses at %0d want 1 at 18", done_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int reached;
    reached = 0;
    @(negedge clk);
    start = 1'b1; len = AW'(4); out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && rd_addr == AW'(1)) begin
        out_ready = 1'b0;
        reached = 1;
        break;
      end
    end
    vectors++; if (reached !== 1) begin miscompares++; $display("FAIL rmid_reach got %0d want 1", reached); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rmid_ctrl got valid=%b busy=%b want 0/0", out_valid, busy);
    end
    vectors++; if (rd_addr !== '0) begin miscompares++; $display("FAIL rmid_addr got %0d want 0", rd_addr); end
    vectors++; if (char_a !== 8'h00 || char_b !== 8'h00) begin
      miscompares++; $display("FAIL rmid_chars got %h/%h want 00/00", char_a, char_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL rmid_after%0d got done=%b busy=%b want 0/0", c, done, busy);
      end
    end
  endtask

  task automatic test_len_zero();
    run(0, -1, 0, 1, 3, 50);
    vectors++; if (first_valid !== -1 || q_a.size() !== 0) begin
      miscompares++; $display("FAIL zero_valid got first=%0d pairs=%0d want -1/0", first_valid, q_a.size());
    end
    vectors++; if (done_cnt !== 1 || done_cyc !== 1) begin
      miscompares++; $display("FAIL zero_done got %0d pulses at %0d want 1 at 1", done_cnt, done_cyc);
    end
    vectors++; if (busy_first !== 1) begin miscompares++; $display("FAIL zero_busy got %0d want 1", busy_first); end
    vectors++; if (busy_after !== 0) begin miscompares++; $display("FAIL zero_fin_start got busy=%0d want 0", busy_after); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL zero_idle got busy=%b valid=%b want 0/0", busy, out_valid);
    end
  endtask

  task automatic test_illegal_sat();
    for (int i = 0; i < N; i++) begin
      ram_a[i] = 3'(i % 8);
      ram_b[i] = 3'((i * 3) % 8);
    end
    ram_a[0] = 3'b111;
    ram_b[0] = 3'b101;
    run(N + 5, -1, 0, -1, 0, 600);
    vectors++; if (timed_out !== 0) begin miscompares++; $display("FAIL sat_timeout got %0d want 0", timed_out); end
    vectors++; if (q_a.size() !== N) begin miscompares++; $display("FAIL sat_count got %0d want %0d", q_a.size(), N); end
    vectors++; if (q_a.size() > 0 && (q_a[0] !== 8'h3F || q_b[0] !== 8'h3F)) begin
      miscompares++; $display("FAIL sat_illegal got %h/%h want 3f/3f", q_a[0], q_b[0]);
    end
    vectors++; if (q_addr.size() > 0 && q_addr[q_addr.size()-1] !== N - 1) begin
      miscompares++; $display("FAIL sat_last_addr got %0d want %0d", q_addr[q_addr.size()-1], N - 1);
    end
    for (int i = 0; i < q_a.size() && i < N; i++) begin
      vectors++; if (q_a[i] !== ref_char(ram_a[i]) || q_b[i] !== ref_char(ram_b[i]) || q_addr[i] !== i) begin
        miscompares++;
        $display("FAIL sat_pair%0d got %h/%h@%0d want %h/%h@%0d", i, q_a[i], q_b[i], q_addr[i],
                 ref_char(ram_a[i]), ref_char(ram_b[i]), i);
      end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL sat_done got %0d want 1", done_cnt); end
  endtask

  // Fresh start after a long run, with a second start pulse in the first HOLD cycle.
  task automatic test_restart();
    load_basic();
    run(4, -1, 0, 3, 2, 100);
    vectors++; if (q_a.size() !== 4) begin miscompares++; $display("FAIL rst_count got %0d want 4", q_a.size()); end
    for (int i = 0; i < 4 && i < q_a.size(); i++) begin
      vectors++; if (q_a[i] !== exp_a[i] || q_b[i] !== exp_b[i] || q_addr[i] !== i) begin
        miscompares++;
        $display("FAIL restart_pair%0d got %h/%h@%0d want %h/%h@%0d", i, q_a[i], q_b[i], q_addr[i], exp_a[i], exp_b[i], i);
      end
    end
    vectors++; if (done_cnt !== 1 || busy_after !== 0) begin
      miscompares++; $display("FAIL restart_done got %0d pulses busy_after=%0d want 1/0", done_cnt, busy_after);
    end
  endtask

  initial begin
    load_basic();
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_len_zero();
    test_illegal_sat();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
